host_loader: RTL and testbench

Upstream feeder for the tpu top level. Accepts a framed byte stream from an off-chip host over a valid/ready interface and decodes packet headers. Each payload byte is forwarded onto the shared 8-bit ui_in bus with exactly one of fetch_w / fetch_inp / fetch_ins asserted. A start packet produces the start pulse, then the block locks out the host for a fixed run window.

---
 rtl/tpu_pkg.sv | 26 ++
 rtl/host_loader.sv | 122 ++++++++++++
 tb/tb_host_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the tpu host-side loader: header opcodes, loader
// states and the header field layout.
package tpu_pkg;

  typedef enum logic [1:0] {
    OP_WEIGHT = 2'b00,
    OP_INPUT  = 2'b01,
    OP_INSTR  = 2'b10,
    OP_START  = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    RUN
  } ld_state_t;

  // Header byte layout: opcode in the top two bits, (length - 1) below it.
  localparam int HDR_OP_HI  = 7;
  localparam int HDR_OP_LO  = 6;
  localparam int HDR_LEN_HI = 5;
  localparam int HDR_LEN_LO = 0;
  localparam int HDR_LEN_W  = HDR_LEN_HI - HDR_LEN_LO + 1;

endpackage

// File: rtl/host_loader.sv
// Host byte-stream loader: decodes packet headers and forwards payload bytes
// onto ui_in with one fetch strobe, or runs the start pulse plus lockout window.
module host_loader
  import tpu_pkg::*;
#(
  parameter int START_CYCLES = 2,
  parameter int RUN_CYCLES   = 32,
  parameter int LEN_W        = HDR_LEN_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] host_data,
  input  logic       host_valid,
  output logic       host_ready,
  output logic [7:0] ui_in,
  output logic       fetch_w,
  output logic       fetch_inp,
  output logic       fetch_ins,
  output logic       start,
  output logic       busy,
  output logic       pkt_done
);

  localparam int MAX_CYC = (START_CYCLES > RUN_CYCLES) ? START_CYCLES : RUN_CYCLES;
  localparam int CYC_W   = $clog2(MAX_CYC) + 1;
  localparam int CNT_W   = ((LEN_W + 1) > CYC_W) ? (LEN_W + 1) : CYC_W;

  ld_state_t        state;
  opcode_t          target;
  opcode_t          hdr_op;
  logic [CNT_W-1:0] cnt;
  logic             xfer;

  // Ready depends only on state (and reset), never on host_valid, so the
  // host may wait for ready before presenting data without a comb loop.
  assign host_ready = reset && ((state == IDLE) || (state == LOAD));
  assign xfer       = host_valid && host_ready;
  assign hdr_op     = opcode_t'(host_data[HDR_OP_HI:HDR_OP_LO]);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking writes would make results order-dependent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      target    <= OP_WEIGHT;
      cnt       <= '0;
      ui_in     <= '0;
      fetch_w   <= 1'b0;
      fetch_inp <= 1'b0;
      fetch_ins <= 1'b0;
      start     <= 1'b0;
      busy      <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      fetch_w   <= 1'b0;
      fetch_inp <= 1'b0;
      fetch_ins <= 1'b0;
      pkt_done  <= 1'b0;

      case (state)
        IDLE: begin
          if (xfer) begin
            busy <= 1'b1;
            if (hdr_op == OP_START) begin
              state <= START;
              start <= 1'b1;
              cnt   <= CNT_W'(START_CYCLES - 1);
            end else begin
              state  <= LOAD;
              target <= hdr_op;
              cnt    <= CNT_W'(host_data[LEN_W-1:0]) + CNT_W'(1);
            end
          end
        end

        LOAD: begin
          if (xfer) begin
            ui_in <= host_data;
            case (target)
              OP_WEIGHT: fetch_w   <= 1'b1;
              OP_INPUT:  fetch_inp <= 1'b1;
              default:   fetch_ins <= 1'b1;
            endcase
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state    <= IDLE;
              busy     <= 1'b0;
              pkt_done <= 1'b1;
            end
          end
        end

        START: begin
          if (cnt == '0) begin
            state <= RUN;
            start <= 1'b0;
            cnt   <= CNT_W'(RUN_CYCLES - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        RUN: begin
          if (cnt == '0) begin
            state    <= IDLE;
            busy     <= 1'b0;
            pkt_done <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          start <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_loader.sv
// Randomized self-checking bench for host_loader: a packet-level scoreboard
// predicts every output cycle from the bytes the host actually handed over.
module tb_host_loader;

  localparam int S = 2;
  localparam int R = 32;

  // kind: 0 weight byte, 1 input byte, 2 instruction byte, 3 load header, 4 start header
  typedef struct {
    logic [7:0] data;
    int         kind;
    bit         last;
  } item_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] host_data;
  logic       host_valid;
  logic       host_ready;
  logic [7:0] ui_in;
  logic       fetch_w, fetch_inp, fetch_ins, start, busy, pkt_done;

  int total = 0;
  int bad   = 0;

  item_t      exp_q[$];
  int         inp_log[$];
  logic [7:0] pay[64];
  bit         mon_en = 1'b0;
  int         cyc = 0;
  int         lock_k = 0;
  logic [2:0] nd_f = '0;
  bit         nd_done = 1'b0;
  bit         load_busy = 1'b0;
  logic [7:0] last_ui = '0;
  int         done_cnt = 0;
  int         pkts_exp = 0;

  host_loader #(.START_CYCLES(S), .RUN_CYCLES(R), .LEN_W(6)) dut (
    .clk(clk), .reset(reset), .host_data(host_data), .host_valid(host_valid),
    .host_ready(host_ready), .ui_in(ui_in), .fetch_w(fetch_w), .fetch_inp(fetch_inp),
    .fetch_ins(fetch_ins), .start(start), .busy(busy), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h want=%0h", tag, $time, got, want);
    end
  endtask

  // Scoreboard: check this cycle's outputs, then predict the next cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      bit in_start, in_lock, e_done;
      item_t it;
      cyc++;
      in_start = (lock_k >= 1) && (lock_k <= S);
      in_lock  = (lock_k >= 1) && (lock_k <= S + R);
      e_done   = nd_done || (lock_k == S + R + 1);
      check("fetch_w",   fetch_w,   nd_f[0]);
      check("fetch_inp", fetch_inp, nd_f[1]);
      check("fetch_ins", fetch_ins, nd_f[2]);
      check("ui_in",     ui_in,     last_ui);
      check("start",     start,     in_start);
      check("host_ready", host_ready, !in_lock);
      check("busy",      busy,      load_busy || in_lock);
      check("pkt_done",  pkt_done,  e_done);
      check("excl", ($countones({fetch_w, fetch_inp, fetch_ins, start}) <= 1), 1);
      if (pkt_done) done_cnt++;
      if (fetch_inp) inp_log.push_back(cyc);

      if (lock_k > 0) lock_k = (lock_k == S + R + 1) ? 0 : lock_k + 1;
      nd_f    = '0;
      nd_done = 1'b0;
      if (host_valid && host_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 1, 0);
        end else begin
          it = exp_q.pop_front();
          check("xfer_data", host_data, it.data);
          if (it.kind == 4) begin
            lock_k = 1;
          end else if (it.kind == 3) begin
            load_busy = 1'b1;
          end else begin
            nd_f[it.kind] = 1'b1;
            last_ui = it.data;
            if (it.last) begin
              nd_done   = 1'b1;
              load_busy = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input int kind, input bit last);
    item_t it;
    int n;
    it.data = d; it.kind = kind; it.last = last;
    exp_q.push_back(it);
    host_data  = d;
    host_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        $display("FAIL ready_timeout: got=no_ready want=ready within 300 cycles");
        $fatal(1, "host_ready never asserted");
      end
    end while (!host_ready);
    @(posedge clk);
    #1 host_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one packet using pay[] as payload; random gaps of up to gmax cycles.
  task automatic send_packet(input int op, input int len, input int gmax);
    logic [7:0] hdr;
    hdr = {op[1:0], len[5:0]};
    pkts_exp++;
    if (op == 3) begin
      send_byte(hdr, 4, 1'b0);
    end else begin
      send_byte(hdr, 3, 1'b0);
      for (int i = 0; i <= len; i++) begin
        if (gmax > 0) idle($urandom_range(0, gmax));
        send_byte(pay[i], op, i == len);
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    host_valid = 1'b0;
    host_data  = '0;
    #12;
    check("rst_ready", host_ready, 0);
    check("rst_outs", {ui_in, fetch_w, fetch_inp, fetch_ins, start, busy, pkt_done}, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #2 mon_en = 1'b1;
    #1;

    // weight load, continuous
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    send_packet(0, 3, 0);
    idle(2);

    // gapped input load: fetch_inp pulses must be 4 cycles apart
    inp_log.delete();
    pkts_exp++;
    send_byte(8'h41, 3, 1'b0);
    send_byte(8'hA5, 1, 1'b0);
    idle(3);
    send_byte(8'h5A, 1, 1'b1);
    idle(2);
    check("gap_pulses", inp_log.size(), 2);
    if (inp_log.size() == 2) check("gap_spacing", inp_log[1] - inp_log[0], 4);

    // start packet with a weight header offered during lockout
    send_packet(3, 0, 0);
    pay[0] = 8'h9C;
    send_packet(0, 0, 0);
    idle(2);

    // maximum length instruction packet
    for (int i = 0; i < 64; i++) pay[i] = 8'(i);
    send_packet(2, 63, 0);

    // back-to-back weight then input
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    send_packet(0, 3, 0);
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    send_packet(1, 3, 0);
    idle(2);

    // reset mid-load after 2 of 4 payload bytes
    send_byte(8'h03, 3, 1'b0);
    send_byte(8'hDE, 0, 1'b0);
    send_byte(8'hAD, 0, 1'b0);
    @(posedge clk);
    #2 mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_ready", host_ready, 0);
    check("midrst_outs", {ui_in, fetch_w, fetch_inp, fetch_ins, start, busy, pkt_done}, 0);
    exp_q.delete();
    lock_k = 0; nd_f = '0; nd_done = 1'b0; load_busy = 1'b0; last_ui = '0;
    idle(2);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 mon_en = 1'b1;
    #1;
    pay[0] = 8'h5C; pay[1] = 8'hC5;
    send_packet(2, 1, 0);

    // randomized packets
    for (int p = 0; p < 25; p++) begin
      int op, len, gmax;
      op   = $urandom_range(0, 3);
      len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
      gmax = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      send_packet(op, len, gmax);
    end

    idle(S + R + 8);
    check("pkt_count", done_cnt, pkts_exp);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
